// File: rtl/spi_master_02.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_02                                                   |
// | Purpose  : Parametrised full-duplex SPI master. One start launches one     |
// |            word transfer with a runtime SPI mode (cpol/cpha), a runtime    |
// |            sck divider, one of NUM_CS active-low chip selects and an       |
// |            optional chip-select hold for multi-word bursts.                |
// | Ports    : clk, rst (async, active-low)                                    |
// |            start, data_in, cs_sel, cpol, cpha, div, hold - command, all    |
// |              latched on the accept edge (start while idle)                 |
// |            miso            - serial data from the slave                    |
// |            sck, mosi, cs_n - SPI pins (registered)                         |
// |            busy            - transfer in flight                            |
// |            new_data        - one-cycle pulse, data_out updated             |
// |            data_out        - last received word                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spi_master_02 #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 1,
  parameter int DIV_WIDTH  = 8,
  parameter int CS_WIDTH   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CS_WIDTH-1:0]   cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  hold,
  input  logic                  miso,
  output logic                  sck,
  output logic                  mosi,
  output logic [NUM_CS-1:0]     cs_n,
  output logic                  busy,
  output logic                  new_data,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;
  // Edge counter holds the number of ticks already taken; this value marks
  // the final (2*DATA_WIDTH-th) edge of the word.
  localparam logic [BIT_CNT_W-1:0] LAST_EDGE = BIT_CNT_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_hold;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [CS_WIDTH-1:0]   r_cs_sel;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [BIT_CNT_W-1:0]  r_edge_cnt;

  logic                  w_tick;
  logic                  w_lead;
  logic                  w_last;
  logic [NUM_CS-1:0]     w_cs_dec_n;

  assign w_tick = (r_cnt == r_div);
  // Edges are numbered from 1: odd edges (even count of prior ticks) lead.
  assign w_lead = ~r_edge_cnt[0];
  assign w_last = (r_edge_cnt == LAST_EDGE);

  // One-cold decode; an out-of-range index selects no line at all.
  always_comb begin
    w_cs_dec_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (r_cs_sel == CS_WIDTH'(i)) w_cs_dec_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_hold     <= 1'b0;
      r_div      <= '0;
      r_cs_sel   <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= '1;
      busy       <= 1'b0;
      new_data   <= 1'b0;
      data_out   <= '0;
    end else begin
      new_data <= 1'b0;
      // Half-period counter runs in every active state and wraps on its tick,
      // so state changes always land on a half-period boundary.
      if (r_state != IDLE) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          sck <= r_cpol;
          if (start) begin
            r_cpol     <= cpol;
            r_cpha     <= cpha;
            r_div      <= div;
            r_hold     <= hold;
            r_cs_sel   <= cs_sel;
            r_tx       <= data_in;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            busy       <= 1'b1;
            sck        <= cpol;
            if (!cpha) mosi <= data_in[DATA_WIDTH-1];
            // A chip select still held from a previous burst is dropped
            // before a different slave is addressed.
            if (cs_sel != r_cs_sel) cs_n <= '1;
            r_state    <= SETUP;
          end
        end

        SETUP: begin
          cs_n <= w_cs_dec_n;
          if (w_tick) r_state <= TRANSFER;
        end

        TRANSFER: begin
          if (w_tick) begin
            sck        <= ~sck;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            if (w_lead) begin
              if (r_cpha) begin
                mosi <= r_tx[DATA_WIDTH-1];
                r_tx <= r_tx << 1;
              end else begin
                r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
              end
            end else begin
              if (r_cpha) begin
                r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
              end else if (!w_last) begin
                // MSB already went out during SETUP; present the next bit.
                mosi <= r_tx[DATA_WIDTH-2];
                r_tx <= r_tx << 1;
              end
            end
            if (w_last) r_state <= DONE;
          end
        end

        DONE: begin
          if (w_tick) begin
            data_out <= r_rx;
            new_data <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
            if (!r_hold) begin
              cs_n <= '1;
              mosi <= 1'b0;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_02.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_master_02                                                |
// | Purpose  : Directed self-checking bench for spi_master_02 (8-bit words,    |
// |            four chip selects). Cycle n means the sample taken #1 after the |
// |            n-th rising edge following the accept edge (cycle 0).          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_master_02;

  localparam int DW   = 8;
  localparam int NCS  = 4;
  localparam int DIVW = 8;
  localparam int CSW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   data_in;
  logic [CSW-1:0]  cs_sel;
  logic            cpol;
  logic            cpha;
  logic [DIVW-1:0] div;
  logic            hold;
  logic            miso;
  logic            sck;
  logic            mosi;
  logic [NCS-1:0]  cs_n;
  logic            busy;
  logic            new_data;
  logic [DW-1:0]   data_out;

  always #5 clk = ~clk;

  spi_master_02 #(
    .DATA_WIDTH(DW),
    .NUM_CS    (NCS),
    .DIV_WIDTH (DIVW),
    .CS_WIDTH  (CSW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .cs_sel  (cs_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .div     (div),
    .hold    (hold),
    .miso    (miso),
    .sck     (sck),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .busy    (busy),
    .new_data(new_data),
    .data_out(data_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model / loopback ----------------
  logic       loopback = 1'b1;
  logic       slave_miso;
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_rx;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic       load_tog = 1'b0;
  logic       load_seen = 1'b0;
  int         sbit;

  assign miso = loopback ? mosi : slave_miso;

  // Slave shifts out on the edge opposite to the master's sample edge and
  // captures mosi on the master's sample edge; only while selected.
  always @(sck, load_tog) begin
    if (load_tog != load_seen) begin
      load_seen  = load_tog;
      sbit       = s_cpha ? 7 : 6;
      slave_miso = s_cpha ? 1'b0 : slave_word[7];
      slave_rx   = 8'h00;
    end else if (!(&cs_n)) begin
      if ((sck != s_cpol) == s_cpha) begin
        if (sbit >= 0) begin
          slave_miso = slave_word[sbit];
          sbit--;
        end
      end else begin
        slave_rx = {slave_rx[6:0], mosi};
      end
    end
  end

  // More than one chip select low at any sample is an error.
  int multi_low = 0;
  always @(negedge clk) begin
    if (rst === 1'b1 && $countones(~cs_n) > 1) multi_low++;
  end

  // Drive a command and return #1 after its accept edge.
  task automatic start_word(input logic p_cpol, input logic p_cpha, input logic [7:0] p_div,
                            input logic [7:0] p_data, input logic [1:0] p_sel, input logic p_hold,
                            input logic p_loop, input logic [7:0] p_slave);
    cpol       = p_cpol;
    cpha       = p_cpha;
    div        = p_div;
    data_in    = p_data;
    cs_sel     = p_sel;
    hold       = p_hold;
    loopback   = p_loop;
    s_cpol     = p_cpol;
    s_cpha     = p_cpha;
    slave_word = p_slave;
    load_tog   = ~load_tog;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follow a transfer up to new_data (bounded). Counts leading sck edges,
  // records the first two, and counts cycles (1..new_data-1) where cs_n
  // differs from cs_exp. Optional stray start pulses at given cycles.
  task automatic run(input logic p_cpol, input logic [3:0] cs_exp, input int pulse_a,
                     input int pulse_b, output int nd_cyc, output int leads,
                     output int lead1, output int lead2, output int cs_bad);
    logic prev;
    prev   = sck;
    nd_cyc = -1;
    leads  = 0;
    lead1  = -1;
    lead2  = -1;
    cs_bad = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      start = (c == pulse_a) || (c == pulse_b);
      if (start) begin
        data_in = 8'hFF;
        cs_sel  = 2'd3;
        hold    = 1'b1;
      end
      if (sck != prev && sck != p_cpol) begin
        leads++;
        if (lead1 < 0) lead1 = c;
        else if (lead2 < 0) lead2 = c;
      end
      prev = sck;
      if (new_data) begin
        nd_cyc = c;
        break;
      end
      if (cs_n != cs_exp) cs_bad++;
    end
  endtask

  initial begin
    int nd, ld, l1, l2, csb, extra;
    rst     = 1'b0;
    start   = 1'b0;
    data_in = '0;
    cs_sel  = '0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    div     = '0;
    hold    = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_new_data", new_data, 0);
    check("rst_data_out", data_out, 0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- mode 0, div 0, loopback 0xA5 ----------------
    start_word(1'b0, 1'b0, 8'd0, 8'hA5, 2'd0, 1'b0, 1'b1, 8'h00);
    check("m0_sck_idle", sck, 0);
    check("m0_busy", busy, 1);
    run(1'b0, 4'b1110, -1, -1, nd, ld, l1, l2, csb);
    check("m0_nd_cycle", nd, 18);
    check("m0_rises", ld, 8);
    check("m0_first_rise", l1, 2);
    check("m0_period", l2 - l1, 2);
    check("m0_cs_low", csb, 0);
    check("m0_data_out", data_out, 8'hA5);
    check("m0_busy_end", busy, 0);
    check("m0_cs_release", cs_n, 4'hF);
    check("m0_mosi_end", mosi, 0);
    @(posedge clk);
    #1;
    check("m0_nd_pulse", new_data, 0);

    // ---------------- mode 3, div 3, slave returns 0xC3 ----------------
    start_word(1'b1, 1'b1, 8'd3, 8'h3C, 2'd0, 1'b0, 1'b0, 8'hC3);
    check("m3_sck_idle", sck, 1);
    run(1'b1, 4'b1110, -1, -1, nd, ld, l1, l2, csb);
    check("m3_nd_cycle", nd, 72);
    check("m3_falls", ld, 8);
    check("m3_period", l2 - l1, 8);
    check("m3_cs_low", csb, 0);
    check("m3_data_out", data_out, 8'hC3);
    check("m3_slave_rx", slave_rx, 8'h3C);
    check("m3_sck_end", sck, 1);
    check("m3_cs_release", cs_n, 4'hF);

    // ---------------- burst on cs 2: hold 0x11, then 0x22 ----------------
    start_word(1'b0, 1'b0, 8'd0, 8'h11, 2'd2, 1'b1, 1'b1, 8'h00);
    run(1'b0, 4'b1011, -1, -1, nd, ld, l1, l2, csb);
    check("b1_nd_cycle", nd, 18);
    check("b1_cs_low", csb, 0);
    check("b1_data_out", data_out, 8'h11);
    check("b1_cs_held", cs_n, 4'b1011);
    start_word(1'b0, 1'b0, 8'd0, 8'h22, 2'd2, 1'b0, 1'b1, 8'h00);
    check("b2_cs_accept", cs_n, 4'b1011);
    run(1'b0, 4'b1011, -1, -1, nd, ld, l1, l2, csb);
    check("b2_nd_cycle", nd, 18);
    check("b2_cs_low", csb, 0);
    check("b2_data_out", data_out, 8'h22);
    check("b2_cs_release", cs_n, 4'hF);

    // ---------------- held cs 1, then switch to cs 3 ----------------
    start_word(1'b0, 1'b0, 8'd0, 8'h0F, 2'd1, 1'b1, 1'b1, 8'h00);
    run(1'b0, 4'b1101, -1, -1, nd, ld, l1, l2, csb);
    check("sw1_cs_low", csb, 0);
    check("sw1_cs_held", cs_n, 4'b1101);
    start_word(1'b0, 1'b0, 8'd0, 8'hF0, 2'd3, 1'b0, 1'b1, 8'h00);
    check("sw2_cs_accept", cs_n, 4'hF);
    run(1'b0, 4'b0111, -1, -1, nd, ld, l1, l2, csb);
    check("sw2_cs_low", csb, 0);
    check("sw2_data_out", data_out, 8'hF0);

    // ---------------- stray starts at cycles 5 and 10 ----------------
    start_word(1'b0, 1'b0, 8'd0, 8'h96, 2'd0, 1'b0, 1'b1, 8'h00);
    run(1'b0, 4'b1110, 5, 10, nd, ld, l1, l2, csb);
    check("ig_nd_cycle", nd, 18);
    check("ig_data_out", data_out, 8'h96);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (new_data) extra++;
    end
    check("ig_extra_nd", extra, 0);
    check("ig_cs_idle", cs_n, 4'hF);
    check("ig_data_hold", data_out, 8'h96);

    // ---------------- reset at cycle 9 of a mode-1 transfer ----------------
    start_word(1'b0, 1'b1, 8'd1, 8'hE7, 2'd0, 1'b0, 1'b1, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
    end
    check("pr_sck_high", sck, 1);
    check("pr_cs_low", cs_n, 4'b1110);
    rst = 1'b0;
    #1;
    check("ar_sck", sck, 0);
    check("ar_cs_n", cs_n, 4'hF);
    check("ar_busy", busy, 0);
    check("ar_data_out", data_out, 0);
    check("ar_mosi", mosi, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_word(1'b0, 1'b1, 8'd0, 8'h5A, 2'd0, 1'b0, 1'b1, 8'h00);
    check("rr_busy", busy, 1);
    run(1'b0, 4'b1110, -1, -1, nd, ld, l1, l2, csb);
    check("rr_nd_cycle", nd, 18);
    check("rr_data_out", data_out, 8'h5A);
    check("rr_cs_low", csb, 0);

    check("cs_one_low", multi_low, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
